// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: valid/ready pipeline stage with synchronous flush and optional two-entry skid buffer.
// DEFAULT_VAL bubbles are loaded on reset, flush and drain so out_data is well defined when idle.
module pipe_skid_reg #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] DEFAULT_VAL = '0,
    parameter bit               SKID        = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] BUSY  = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    if (SKID) begin : g_skid
        logic [1:0]       state, state_nxt;
        logic [WIDTH-1:0] main_q, skid_q;
        logic             rdy_q;
        logic             in_fire, out_fire;
        assign in_fire  = in_valid && rdy_q;
        assign out_fire = (state != EMPTY) && out_ready;
        // in_ready comes straight from a flop so out_ready never reaches it combinationally
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state <= EMPTY;
                rdy_q <= 1'b1;
            end else begin
                state <= state_nxt;
                rdy_q <= state_nxt != FULL;
            end
        end
        always_comb begin
            state_nxt = flush             ? EMPTY :
                        state == EMPTY    ? (in_fire ? BUSY : EMPTY) :
                        state == BUSY     ? ((in_fire && !out_fire) ? FULL :
                                             (!in_fire && out_fire) ? EMPTY : BUSY) :
                                            (out_fire ? BUSY : FULL);
        end
        always_ff @(posedge clk or negedge reset) begin
            if (!reset || flush) begin
                main_q <= DEFAULT_VAL;
                skid_q <= DEFAULT_VAL;
            end else if (state == EMPTY) begin
                if (in_fire) main_q <= in_data;
            end else if (state == BUSY) begin
                if (in_fire && out_fire) main_q <= in_data;
                else if (in_fire) skid_q <= in_data;
                else if (out_fire) main_q <= DEFAULT_VAL;
            end else if (out_fire) begin
                main_q <= skid_q;
                skid_q <= DEFAULT_VAL;
            end
        end
        always_comb begin
            in_ready  = rdy_q;
            out_valid = state != EMPTY;
            out_data  = main_q;
            occupancy = state;
        end
    end else begin : g_plain
        logic [WIDTH-1:0] main_q;
        logic             valid_q;
        logic             in_fire, out_fire;
        assign in_fire  = in_valid && in_ready;
        assign out_fire = valid_q && out_ready;
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                main_q  <= DEFAULT_VAL;
                valid_q <= 1'b0;
            end else if (flush) begin
                main_q  <= DEFAULT_VAL;
                valid_q <= 1'b0;
            end else if (in_fire) begin
                main_q  <= in_data;
                valid_q <= 1'b1;
            end else if (out_fire) begin
                main_q  <= DEFAULT_VAL;
                valid_q <= 1'b0;
            end
        end
        always_comb begin
            in_ready  = !valid_q || out_ready;
            out_valid = valid_q;
            out_data  = main_q;
            occupancy = {1'b0, valid_q};
        end
    end
endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: drives SKID=1 and SKID=0 instances with shared stimulus and checks both
// against a queue-based reference model, plus directed table and corner sequences.
module tb_pipe_skid_reg;
    localparam logic [31:0] DEF = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        out_ready = 1'b0;

    logic        rdy1, val1, rdy0, val0;
    logic [31:0] dat1, dat0;
    logic [1:0]  occ1, occ0;

    int tests = 0;
    int errors = 0;
    logic [31:0] q1[$];
    logic [31:0] q0[$];

    always #5 clk = ~clk;

    pipe_skid_reg #(.WIDTH(32), .DEFAULT_VAL(DEF), .SKID(1'b1)) dut1 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy1),
        .in_data(in_data), .out_valid(val1), .out_ready(out_ready), .out_data(dat1), .occupancy(occ1));

    pipe_skid_reg #(.WIDTH(32), .DEFAULT_VAL(DEF), .SKID(1'b0)) dut0 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy0),
        .in_data(in_data), .out_valid(val0), .out_ready(out_ready), .out_data(dat0), .occupancy(occ0));

    typedef struct {
        logic        fl;
        logic        iv;
        logic [31:0] id;
        logic        ordy;
        logic        ev;
        logic [31:0] ed;
        logic [1:0]  eo;
        logic        er;
    } vec_t;
    vec_t tbl[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("s1_valid", {31'd0, val1}, {31'd0, q1.size() != 0});
        chk("s1_data", dat1, q1.size() != 0 ? q1[0] : DEF);
        chk("s1_occ", {30'd0, occ1}, q1.size());
        chk("s1_ready", {31'd0, rdy1}, {31'd0, q1.size() < 2});
        chk("s0_valid", {31'd0, val0}, {31'd0, q0.size() != 0});
        chk("s0_data", dat0, q0.size() != 0 ? q0[0] : DEF);
        chk("s0_occ", {30'd0, occ0}, q0.size());
        chk("s0_ready", {31'd0, rdy0}, {31'd0, q0.size() == 0 || out_ready});
    endtask

    task automatic drive(input logic fl, input logic iv, input logic [31:0] id, input logic ordy);
        flush = fl;
        in_valid = iv;
        in_data = id;
        out_ready = ordy;
        #1;
    endtask

    // Abstract FIFO view: capacity 2 (skid) or 1 (plain); flush empties it.
    task automatic adv();
        bit in1, out1, in0, out0;
        in1  = in_valid && q1.size() < 2;
        out1 = out_ready && q1.size() != 0;
        in0  = in_valid && (q0.size() == 0 || out_ready);
        out0 = out_ready && q0.size() != 0;
        if (flush) begin
            q1.delete();
            q0.delete();
        end else begin
            if (out1) void'(q1.pop_front());
            if (in1) q1.push_back(in_data);
            if (out0) void'(q0.pop_front());
            if (in0) q0.push_back(in_data);
        end
        @(negedge clk);
    endtask

    task automatic cycle(input logic fl, input logic iv, input logic [31:0] id, input logic ordy);
        drive(fl, iv, id, ordy);
        check_model();
        adv();
    endtask

    initial begin
        tbl[0]  = '{1'b0, 1'b1, 32'h1,   1'b1, 1'b0, DEF,   2'd0, 1'b1};
        tbl[1]  = '{1'b0, 1'b1, 32'h2,   1'b1, 1'b1, 32'h1, 2'd1, 1'b1};
        tbl[2]  = '{1'b0, 1'b1, 32'h3,   1'b1, 1'b1, 32'h2, 2'd1, 1'b1};
        tbl[3]  = '{1'b0, 1'b1, 32'hA,   1'b1, 1'b1, 32'h3, 2'd1, 1'b1};
        tbl[4]  = '{1'b0, 1'b1, 32'hB,   1'b0, 1'b1, 32'hA, 2'd1, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'hA, 2'd2, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 32'hE,   1'b0, 1'b1, 32'hA, 2'd2, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'hA, 2'd2, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'hB, 2'd1, 1'b1};
        tbl[9]  = '{1'b0, 1'b1, 32'hA,   1'b0, 1'b0, DEF,   2'd0, 1'b1};
        tbl[10] = '{1'b0, 1'b1, 32'hB,   1'b0, 1'b1, 32'hA, 2'd1, 1'b1};
        tbl[11] = '{1'b1, 1'b1, 32'hC,   1'b0, 1'b1, 32'hA, 2'd2, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 32'h5,   1'b0, 1'b0, DEF,   2'd0, 1'b1};
        tbl[13] = '{1'b1, 1'b1, 32'hC,   1'b1, 1'b1, 32'h5, 2'd1, 1'b1};
        tbl[14] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, DEF,   2'd0, 1'b1};

        // Reset held across edges with live input traffic
        in_valid = 1'b1;
        in_data = 32'hDEAD_BEEF;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_model();
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("rst_rdy1", {31'd0, rdy1}, 32'd1);
        chk("rst_rdy0", {31'd0, rdy0}, 32'd1);

        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].fl, tbl[i].iv, tbl[i].id, tbl[i].ordy);
            chk($sformatf("tbl%0d_valid", i), {31'd0, val1}, {31'd0, tbl[i].ev});
            chk($sformatf("tbl%0d_data", i), dat1, tbl[i].ed);
            chk($sformatf("tbl%0d_occ", i), {30'd0, occ1}, {30'd0, tbl[i].eo});
            chk($sformatf("tbl%0d_ready", i), {31'd0, rdy1}, {31'd0, tbl[i].er});
            check_model();
            adv();
        end

        // SKID=0: in_ready follows out_ready combinationally within one cycle
        cycle(1'b0, 1'b1, 32'h77, 1'b0);
        drive(1'b0, 1'b1, 32'h88, 1'b0);
        chk("s0_comb_rdy_lo", {31'd0, rdy0}, 32'd0);
        out_ready = 1'b1;
        #1;
        chk("s0_comb_rdy_hi", {31'd0, rdy0}, 32'd1);
        chk("s0_old_word", dat0, 32'h77);
        cycle(1'b0, 1'b1, 32'h88, 1'b1);
        chk("s0_replaced", dat0, 32'h88);
        cycle(1'b1, 1'b0, 32'h0, 1'b0);

        // Async reset mid-stall, between clock edges
        cycle(1'b0, 1'b1, 32'h51, 1'b0);
        cycle(1'b0, 1'b1, 32'h52, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        chk("stall_occ", {30'd0, occ1}, 32'd2);
        #1;
        reset = 1'b0;
        #1;
        chk("arst_valid1", {31'd0, val1}, 32'd0);
        chk("arst_data1", dat1, DEF);
        chk("arst_occ1", {30'd0, occ1}, 32'd0);
        chk("arst_rdy1", {31'd0, rdy1}, 32'd1);
        chk("arst_valid0", {31'd0, val0}, 32'd0);
        chk("arst_data0", dat0, DEF);
        q1.delete();
        q0.delete();
        @(negedge clk);
        reset = 1'b1;

        // Randomised traffic against the reference model
        for (int i = 0; i < 3000; i++)
            cycle($urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0, $urandom,
                  $urandom_range(0, 3) != 0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
